// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    UP_LO,
    UP_HI,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ZERO,
    OP_PY,
    OP_P2Y,
    OP_MY,
    OP_M2Y
  } op_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;

endpackage

// File: rtl/booth_recoder.sv
// Booth digit recoder: maps the multiplier window to an add/subtract selection.
// Radix-2 looks at win[1:0] = {X[0],e}; radix-4 uses the full {X[1],X[0],e}.
module booth_recoder
  import booth_pkg::*;
#(
  parameter bit RADIX4 = 1'b0
) (
  input  logic [2:0] win,
  output op_t        op
);

  // Decode the window into the partial-product selection.
  always_comb begin
    op = OP_ZERO;
    if (RADIX4) begin
      case (win)
        3'b001, 3'b010: op = OP_PY;
        3'b011:         op = OP_P2Y;
        3'b100:         op = OP_M2Y;
        3'b101, 3'b110: op = OP_MY;
        default:        op = OP_ZERO;
      endcase
    end else begin
      case (win[1:0])
        2'b01:   op = OP_PY;
        2'b10:   op = OP_MY;
        default: op = OP_ZERO;
      endcase
    end
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier (radix-2 or radix-4) with a two-beat
// selector-tagged product upload and a registered full product.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          RADIX4 = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x_in,
  input  logic [WIDTH-1:0]     y_in,
  output logic                 busy,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_sel,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int unsigned K     = RADIX4 ? WIDTH / 2 : WIDTH;
  localparam int unsigned SHAMT = RADIX4 ? 2 : 1;
  localparam int unsigned CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_t state, state_nx;

  logic signed [WIDTH+1:0]   a_q;
  logic [WIDTH-1:0]          x_q;
  logic [WIDTH-1:0]          y_q;
  logic                      e_q;
  logic [CW-1:0]             cnt;
  logic [2*WIDTH-1:0]        product_q;

  logic [2:0]                win;
  op_t                       op;
  logic signed [WIDTH+1:0]   y_ext;
  logic signed [WIDTH+1:0]   addend;
  logic signed [WIDTH+1:0]   sum;
  logic signed [2*WIDTH+2:0] cat;
  logic signed [2*WIDTH+2:0] shifted;

  assign win = RADIX4 ? {x_q[1:0], e_q} : {1'b0, x_q[0], e_q};

  booth_recoder #(.RADIX4(RADIX4)) u_recoder (
    .win (win),
    .op  (op)
  );

  // Partial-product selection, add and arithmetic shift of {A,X,e}.
  always_comb begin
    y_ext  = {{2{y_q[WIDTH-1]}}, y_q};
    addend = '0;
    case (op)
      OP_PY:   addend = y_ext;
      OP_P2Y:  addend = y_ext <<< 1;
      OP_MY:   addend = -y_ext;
      OP_M2Y:  addend = -(y_ext <<< 1);
      default: addend = '0;
    endcase
    sum     = a_q + addend;
    cat     = {sum, x_q, e_q};
    shifted = cat >>> SHAMT;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = ITER;
      ITER:    if (cnt == LAST) state_nx = UP_LO;
      UP_LO:   state_nx = UP_HI;
      UP_HI:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers: operand capture, iteration, product latch.
  // Operands are captured on the accepting IDLE edge so LOAD only holds them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      e_q       <= 1'b0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= '0;
            x_q <= x_in;
            y_q <= y_in;
            e_q <= 1'b0;
            cnt <= '0;
          end
        end
        ITER: begin
          a_q <= shifted[2*WIDTH+2 -: WIDTH+2];
          x_q <= shifted[WIDTH:1];
          e_q <= shifted[0];
          cnt <= cnt + 1'b1;
        end
        UP_HI:   product_q <= {a_q[WIDTH-1:0], x_q};
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state register and datapath registers only.
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    out_sel  = SEL_NONE;
    out_data = '0;
    case (state)
      UP_LO: begin
        out_sel  = SEL_LO;
        out_data = x_q;
      end
      UP_HI: begin
        out_sel  = SEL_HI;
        out_data = a_q[WIDTH-1:0];
      end
      default: ;
    endcase
    out_valid = (out_sel != SEL_NONE);
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: four instances (WIDTH 8/4 x radix-2/4).
module tb_booth_mult_seq;
  import booth_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0 = radix-2, index 1 = radix-4.
  logic        start8 [2];
  logic [7:0]  x8 [2], y8 [2], odata8 [2];
  logic [1:0]  osel8 [2];
  logic        busy8 [2], ovalid8 [2], done8 [2];
  logic [15:0] prod8 [2];

  logic        start4 [2];
  logic [3:0]  x4 [2], y4 [2], odata4 [2];
  logic [1:0]  osel4 [2];
  logic        busy4 [2], ovalid4 [2], done4 [2];
  logic [7:0]  prod4 [2];

  int n_cmp = 0;
  int n_bad = 0;

  booth_mult_seq #(.WIDTH(8), .RADIX4(1'b0)) u_w8_r2 (
    .clk(clk), .rst(rst), .start(start8[0]), .x_in(x8[0]), .y_in(y8[0]),
    .busy(busy8[0]), .out_data(odata8[0]), .out_sel(osel8[0]),
    .out_valid(ovalid8[0]), .product(prod8[0]), .done(done8[0]));

  booth_mult_seq #(.WIDTH(8), .RADIX4(1'b1)) u_w8_r4 (
    .clk(clk), .rst(rst), .start(start8[1]), .x_in(x8[1]), .y_in(y8[1]),
    .busy(busy8[1]), .out_data(odata8[1]), .out_sel(osel8[1]),
    .out_valid(ovalid8[1]), .product(prod8[1]), .done(done8[1]));

  booth_mult_seq #(.WIDTH(4), .RADIX4(1'b0)) u_w4_r2 (
    .clk(clk), .rst(rst), .start(start4[0]), .x_in(x4[0]), .y_in(y4[0]),
    .busy(busy4[0]), .out_data(odata4[0]), .out_sel(osel4[0]),
    .out_valid(ovalid4[0]), .product(prod4[0]), .done(done4[0]));

  booth_mult_seq #(.WIDTH(4), .RADIX4(1'b1)) u_w4_r4 (
    .clk(clk), .rst(rst), .start(start4[1]), .x_in(x4[1]), .y_in(y4[1]),
    .busy(busy4[1]), .out_data(odata4[1]), .out_sel(osel4[1]),
    .out_valid(ovalid4[1]), .product(prod4[1]), .done(done4[1]));

  // Runs one 8-bit operation; cycle numbers are relative to the start cycle (0).
  task automatic run8(input int r, input logic [7:0] xa, input logic [7:0] ya,
                      output logic [7:0] lo, output logic [7:0] hi,
                      output logic [15:0] prod, output int lo_c, output int hi_c,
                      output int done_c, output logic busy_after);
    lo = '0; hi = '0; prod = '0;
    lo_c = -1; hi_c = -1; done_c = -1; busy_after = 1'b1;
    @(posedge clk); #1;
    x8[r] = xa; y8[r] = ya; start8[r] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) start8[r] = 1'b0;
      if (osel8[r] == SEL_LO) begin lo = odata8[r]; lo_c = c; end
      if (osel8[r] == SEL_HI) begin hi = odata8[r]; hi_c = c; end
      if (done8[r]) begin done_c = c; prod = prod8[r]; break; end
    end
    if (done_c > 0) begin
      @(posedge clk); #1;
      busy_after = busy8[r];
    end
  endtask

  // Runs one 4-bit operation and reports the product and the DONE cycle.
  task automatic run4(input int r, input logic [3:0] xa, input logic [3:0] ya,
                      output logic [7:0] prod, output int done_c);
    prod = '0; done_c = -1;
    @(posedge clk); #1;
    x4[r] = xa; y4[r] = ya; start4[r] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) start4[r] = 1'b0;
      if (done4[r]) begin done_c = c; prod = prod4[r]; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      n_cmp++;
      if ({busy8[r], done8[r], ovalid8[r], osel8[r], odata8[r], prod8[r]} !== 29'd0) begin
        n_bad++;
        $display("FAIL reset_outputs r4=%0d: busy=%b done=%b valid=%b sel=%b data=%h prod=%h, required all 0",
                 r, busy8[r], done8[r], ovalid8[r], osel8[r], odata8[r], prod8[r]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_radix2_basic;
    logic [7:0] lo, hi; logic [15:0] p; int lc, hc, dc; logic ba;
    run8(0, 8'd3, 8'd5, lo, hi, p, lc, hc, dc, ba);
    n_cmp++; if (lo !== 8'h0F || lc != 10) begin n_bad++;
      $display("FAIL r2_lo: data=%h cycle=%0d, required 0f at 10", lo, lc); end
    n_cmp++; if (hi !== 8'h00 || hc != 11) begin n_bad++;
      $display("FAIL r2_hi: data=%h cycle=%0d, required 00 at 11", hi, hc); end
    n_cmp++; if (p !== 16'h000F || dc != 12) begin n_bad++;
      $display("FAIL r2_done: prod=%h cycle=%0d, required 000f at 12", p, dc); end
    n_cmp++; if (ba !== 1'b0) begin n_bad++;
      $display("FAIL r2_busy_fall: busy=%b in cycle 13, required 0", ba); end
  endtask

  task automatic test_radix4_basic;
    logic [7:0] lo, hi; logic [15:0] p; int lc, hc, dc; logic ba;
    run8(1, 8'hF9, 8'd13, lo, hi, p, lc, hc, dc, ba);
    n_cmp++; if (lo !== 8'hA5 || lc != 6) begin n_bad++;
      $display("FAIL r4_lo: data=%h cycle=%0d, required a5 at 6", lo, lc); end
    n_cmp++; if (hi !== 8'hFF || hc != 7) begin n_bad++;
      $display("FAIL r4_hi: data=%h cycle=%0d, required ff at 7", hi, hc); end
    n_cmp++; if (p !== 16'hFFA5 || dc != 8) begin n_bad++;
      $display("FAIL r4_done: prod=%h cycle=%0d, required ffa5 at 8", p, dc); end
    n_cmp++; if (ba !== 1'b0) begin n_bad++;
      $display("FAIL r4_busy_fall: busy=%b in cycle 9, required 0", ba); end
  endtask

  task automatic test_corners;
    logic [7:0] lo, hi; logic [15:0] p; int lc, hc, dc; logic ba;
    for (int r = 0; r < 2; r++) begin
      run8(r, 8'h80, 8'h80, lo, hi, p, lc, hc, dc, ba);
      n_cmp++; if (p !== 16'h4000 || dc != (r == 1 ? 8 : 12)) begin n_bad++;
        $display("FAIL corner_min_min r4=%0d: prod=%h cycle=%0d, required 4000", r, p, dc); end
      run8(r, 8'h80, 8'h7F, lo, hi, p, lc, hc, dc, ba);
      n_cmp++; if (p !== 16'hC080 || {hi, lo} !== 16'hC080) begin n_bad++;
        $display("FAIL corner_min_max r4=%0d: prod=%h upload=%h%h, required c080", r, p, hi, lo); end
    end
  endtask

  task automatic test_back_to_back;
    int n_done, d1, d2, drained;
    logic [15:0] p1, p2;
    n_done = 0; d1 = -1; d2 = -1; p1 = '0; p2 = '0; drained = 0;
    @(posedge clk); #1;
    x8[0] = 8'd3; y8[0] = 8'd5; start8[0] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      // Changed mid-operation: must not disturb op 1, is picked up by op 2.
      if (c == 5) begin x8[0] = 8'hF9; y8[0] = 8'd13; end
      if (done8[0]) begin
        n_done++;
        if (n_done == 1) begin d1 = c; p1 = prod8[0]; end
        if (n_done == 2) begin d2 = c; p2 = prod8[0]; end
      end
    end
    start8[0] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy8[0]) begin drained = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (n_done != 2 || d1 != 12 || d2 != 25) begin n_bad++;
      $display("FAIL b2b_done_pulses: count=%0d cycles=%0d,%0d, required 2 at 12,25", n_done, d1, d2); end
    n_cmp++; if (p1 !== 16'h000F || p2 !== 16'hFFA5) begin n_bad++;
      $display("FAIL b2b_products: %h,%h, required 000f,ffa5", p1, p2); end
    n_cmp++; if (drained != 1) begin n_bad++;
      $display("FAIL b2b_drain: busy still %b after 40 cycles, required 0", busy8[0]); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] lo, hi; logic [15:0] p; int lc, hc, dc; logic ba;
    logic busy_pre;
    @(posedge clk); #1;
    x8[0] = 8'd100; y8[0] = 8'd77; start8[0] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      start8[0] = 1'b0;
    end
    busy_pre = busy8[0];
    rst = 1'b1;
    #1;
    n_cmp++; if (busy_pre !== 1'b1) begin n_bad++;
      $display("FAIL rst_mid_busy_before: busy=%b in cycle 5, required 1", busy_pre); end
    n_cmp++;
    if ({busy8[0], done8[0], ovalid8[0], osel8[0], odata8[0], prod8[0]} !== 29'd0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b valid=%b sel=%b data=%h prod=%h, required all 0",
               busy8[0], done8[0], ovalid8[0], osel8[0], odata8[0], prod8[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run8(0, 8'd6, 8'hFC, lo, hi, p, lc, hc, dc, ba);
    n_cmp++; if (p !== 16'hFFE8 || {hi, lo} !== 16'hFFE8 || dc != 12) begin n_bad++;
      $display("FAIL rst_mid_fresh_op: prod=%h upload=%h%h cycle=%0d, required ffe8 at 12", p, hi, lo, dc); end
  endtask

  task automatic test_exhaustive_w4;
    logic [7:0] p, expv;
    logic signed [3:0] xs, ys;
    int dc, ref_p;
    for (int r = 0; r < 2; r++) begin
      for (int xi = 0; xi < 16; xi++) begin
        for (int yi = 0; yi < 16; yi++) begin
          xs = 4'(xi); ys = 4'(yi);
          ref_p = int'(xs) * int'(ys);
          expv = ref_p[7:0];
          run4(r, 4'(xi), 4'(yi), p, dc);
          n_cmp++;
          if (p !== expv || dc != (r == 1 ? 6 : 8)) begin
            n_bad++;
            $display("FAIL w4_exhaustive r4=%0d x=%0d y=%0d: prod=%h cycle=%0d, required %h at %0d",
                     r, xs, ys, p, dc, expv, (r == 1 ? 6 : 8));
          end
        end
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 2; r++) begin
      start8[r] = 1'b0; x8[r] = '0; y8[r] = '0;
      start4[r] = 1'b0; x4[r] = '0; y4[r] = '0;
    end
    test_reset();
    test_radix2_basic();
    test_radix4_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive_w4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
